// File: rtl/z88_bus_master.sv
// z88_bus_master: issues single Z80-style memory / I/O cycles toward Blink,
// pacing address setup and strobe width in pm1 T-states, with an mck timeout.
module z88_bus_master #(
    parameter int MEM_TSTATES = 3,
    parameter int IO_TSTATES  = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic        mck,
    input  logic        rin_n,
    input  logic        pm1,
    input  logic        req,
    input  logic        req_io,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [15:0] ca,
    output logic [7:0]  cdi,
    input  logic [7:0]  cdo,
    output logic        mrq_n,
    output logic        ior_n,
    output logic        crd_n,
    output logic        cm1_n,
    output logic        hlt_n
);
    typedef enum logic [1:0] {IDLE, ADDR, STRB, DONE} state_t;

    localparam logic [3:0]  MEM_N = 4'(MEM_TSTATES);
    localparam logic [3:0]  IO_N  = 4'(IO_TSTATES);
    localparam logic [15:0] TOUT  = 16'(TIMEOUT);

    state_t      state, state_nxt;
    logic        busy_nxt, ack_nxt, err_nxt;
    logic [7:0]  rdata_nxt, cdi_nxt;
    logic [15:0] ca_nxt;
    logic        mrq_n_nxt, ior_n_nxt, crd_n_nxt;
    logic        io, io_nxt, wr, wr_nxt;
    logic [15:0] addr, addr_nxt;
    logic [7:0]  wdata, wdata_nxt;
    logic [3:0]  tcnt, tcnt_nxt;
    logic [15:0] timer, timer_nxt, timer_inc;
    logic        tout, tout_nxt;
    logic [3:0]  n_sel;

    assign cm1_n = 1'b1;
    assign hlt_n = 1'b1;
    assign n_sel = io ? IO_N : MEM_N;

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= 8'h00;
            ca    <= 16'h0000;
            cdi   <= 8'h00;
            mrq_n <= 1'b1;
            ior_n <= 1'b1;
            crd_n <= 1'b1;
            io    <= 1'b0;
            wr    <= 1'b0;
            addr  <= 16'h0000;
            wdata <= 8'h00;
            tcnt  <= 4'd0;
            timer <= 16'h0000;
            tout  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            ack   <= ack_nxt;
            err   <= err_nxt;
            rdata <= rdata_nxt;
            ca    <= ca_nxt;
            cdi   <= cdi_nxt;
            mrq_n <= mrq_n_nxt;
            ior_n <= ior_n_nxt;
            crd_n <= crd_n_nxt;
            io    <= io_nxt;
            wr    <= wr_nxt;
            addr  <= addr_nxt;
            wdata <= wdata_nxt;
            tcnt  <= tcnt_nxt;
            timer <= timer_nxt;
            tout  <= tout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_nxt  = busy;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        rdata_nxt = rdata;
        ca_nxt    = ca;
        cdi_nxt   = cdi;
        mrq_n_nxt = mrq_n;
        ior_n_nxt = ior_n;
        crd_n_nxt = crd_n;
        io_nxt    = io;
        wr_nxt    = wr;
        addr_nxt  = addr;
        wdata_nxt = wdata;
        tcnt_nxt  = tcnt;
        timer_nxt = timer;
        tout_nxt  = tout;
        timer_inc = timer + 16'd1;

        case (state)
            IDLE: begin
                // busy is still high during the ack cycle; drop it before accepting again
                if (busy) begin
                    busy_nxt = 1'b0;
                end else if (req) begin
                    io_nxt    = req_io;
                    wr_nxt    = req_wr;
                    addr_nxt  = req_addr;
                    wdata_nxt = req_wdata;
                    timer_nxt = 16'h0000;
                    tout_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR, STRB: begin
                timer_nxt = timer_inc;
                if (timer_inc == TOUT) begin
                    mrq_n_nxt = 1'b1;
                    ior_n_nxt = 1'b1;
                    crd_n_nxt = 1'b1;
                    cdi_nxt   = 8'h00;
                    ca_nxt    = 16'h0000;
                    rdata_nxt = 8'hFF;
                    tout_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (pm1) begin
                    if (state == ADDR) begin
                        ca_nxt    = addr;
                        crd_n_nxt = wr;
                        cdi_nxt   = wr ? wdata : 8'h00;
                        tcnt_nxt  = 4'd0;
                        state_nxt = STRB;
                    end else if (tcnt == 4'd0) begin
                        // one full T-state of address setup has elapsed
                        if (io) ior_n_nxt = 1'b0;
                        else    mrq_n_nxt = 1'b0;
                        tcnt_nxt = 4'd1;
                    end else if (tcnt == n_sel) begin
                        if (!wr) rdata_nxt = cdo;
                        mrq_n_nxt = 1'b1;
                        ior_n_nxt = 1'b1;
                        crd_n_nxt = 1'b1;
                        cdi_nxt   = 8'h00;
                        ca_nxt    = 16'h0000;
                        state_nxt = DONE;
                    end else begin
                        tcnt_nxt = tcnt + 4'd1;
                    end
                end
            end
            DONE: begin
                ack_nxt   = 1'b1;
                err_nxt   = tout;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_z88_bus_master.sv
// Bench for z88_bus_master: Blink responder, bus monitor, shadow-memory
// reference model, directed cases then randomized transactions.
module tb_z88_bus_master;
    localparam int MEM_N = 3;
    localparam int IO_N  = 4;
    localparam int TO    = 1024;

    logic        mck = 1'b0;
    logic        rin_n = 1'b0;
    logic        pm1 = 1'b0;
    logic        req = 1'b0;
    logic        req_io = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [7:0]  req_wdata = 8'h0;
    logic        busy, ack, err;
    logic [7:0]  rdata;
    logic [15:0] ca;
    logic [7:0]  cdi;
    logic [7:0]  cdo = 8'h00;
    logic        mrq_n, ior_n, crd_n, cm1_n, hlt_n;

    z88_bus_master #(.MEM_TSTATES(MEM_N), .IO_TSTATES(IO_N), .TIMEOUT(TO)) dut (
        .mck(mck), .rin_n(rin_n), .pm1(pm1), .req(req), .req_io(req_io),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .ack(ack), .err(err), .rdata(rdata), .ca(ca), .cdi(cdi),
        .cdo(cdo), .mrq_n(mrq_n), .ior_n(ior_n), .crd_n(crd_n),
        .cm1_n(cm1_n), .hlt_n(hlt_n)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pm1_period = 3;
    int phase = 0;

    // Blink-side storage and the bench's own expectation of it
    logic [7:0] blink_io [0:255];
    logic [7:0] blink_mem [0:65535];
    logic [7:0] sh_io [0:255];
    logic [7:0] sh_mem [int];
    logic [7:0] exp_rdata = 8'h00;

    // monitor results
    int          fall_cyc = 0, last_w = -1, last_setup = 0, width = 0;
    int          bus_age = 0, ack_cnt = 0, unstable = 0, both_low = 0;
    logic        last_kind = 1'b0, last_crd = 1'b1, strb_prev = 1'b0;
    logic [15:0] last_ca = 16'h0;
    logic [7:0]  last_cdi = 8'h0;
    logic [24:0] prev_bus = '0;

    initial forever #5 mck = ~mck;
    initial forever begin @(posedge mck); cyc++; end

    function automatic logic [7:0] mem_init(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_exp(input logic [15:0] a);
        if (sh_mem.exists(int'(a))) return sh_mem[int'(a)];
        return mem_init(a);
    endfunction

    // pm1: one mck high every pm1_period cycles, or stopped when 0
    initial forever begin
        @(negedge mck);
        if (pm1_period == 0) begin
            pm1 = 1'b0;
        end else if (phase >= pm1_period - 1) begin
            phase = 0;
            pm1 = 1'b1;
        end else begin
            phase++;
            pm1 = 1'b0;
        end
    end

    // Blink responder: registered read data while a read strobe is low, junk otherwise
    initial forever begin
        @(negedge mck);
        if (!ior_n && !crd_n)      cdo = blink_io[ca[7:0]];
        else if (!mrq_n && !crd_n) cdo = blink_mem[ca];
        else                       cdo = 8'($urandom);
        if (!ior_n && crd_n) blink_io[ca[7:0]] = cdi;
        if (!mrq_n && crd_n) blink_mem[ca] = cdi;
    end

    initial forever begin : monitor
        logic strb;
        @(negedge mck);
        if ({ca, crd_n, cdi} != prev_bus) bus_age = 0;
        else                              bus_age++;
        prev_bus = {ca, crd_n, cdi};
        if (ack) ack_cnt++;
        if (!ior_n && !mrq_n) both_low++;
        strb = !ior_n || !mrq_n;
        if (strb && !strb_prev) begin
            fall_cyc   = cyc;
            last_kind  = !ior_n;
            last_ca    = ca;
            last_crd   = crd_n;
            last_cdi   = cdi;
            last_setup = bus_age;
            width      = 0;
        end
        if (strb) begin
            width++;
            if ({ca, crd_n, cdi} != {last_ca, last_crd, last_cdi}) unstable++;
        end
        if (!strb && strb_prev) last_w = width;
        strb_prev = strb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit io, input bit wr, input logic [15:0] addr,
                         input logic [7:0] wd, input int poke, output int cap,
                         output int ackc, output logic [7:0] rd, output logic er);
        @(negedge mck);
        check("idle_before_req", {30'd0, busy, ack}, 32'd0);
        last_w = -1;
        req = 1'b1; req_io = io; req_wr = wr; req_addr = addr; req_wdata = wd;
        @(negedge mck);
        req = 1'b0;
        req_io = 1'($urandom); req_wr = 1'($urandom);
        req_addr = 16'($urandom); req_wdata = 8'($urandom);
        cap = cyc;
        check("capture_busy", {31'd0, busy}, 32'd1);
        ackc = -1; rd = 8'h00; er = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (ack) begin
                ackc = cyc; rd = rdata; er = err;
                break;
            end
            req = (k == poke);
            @(negedge mck);
        end
        req = 1'b0;
        check("ack_seen", {31'd0, ackc >= 0}, 32'd1);
    endtask

    task automatic txn(input bit io, input bit wr, input logic [15:0] addr,
                       input logic [7:0] wd, input int t);
        int cap, ackc, n, d;
        logic [7:0] rd, exp;
        logic er;
        if (pm1_period != t) begin
            pm1_period = t;
            repeat (6) @(negedge mck);
        end
        n = io ? IO_N : MEM_N;
        exp = wr ? exp_rdata : (io ? sh_io[addr[7:0]] : mem_exp(addr));
        issue(io, wr, addr, wd, -1, cap, ackc, rd, er);
        d = fall_cyc - cap;
        check("rdata", {24'd0, rd}, {24'd0, exp});
        check("err", {31'd0, er}, 32'd0);
        check("strobe_width", last_w, t * n);
        check("first_strobe_window", {31'd0, (d >= t + 1) && (d <= 2 * t)}, 32'd1);
        check("strobe_to_ack", ackc - fall_cyc, t * n + 1);
        check("strobe_kind", {31'd0, last_kind}, {31'd0, io});
        check("ca_in_strobe", {16'd0, last_ca}, {16'd0, addr});
        check("crd_n_in_strobe", {31'd0, last_crd}, {31'd0, wr});
        check("cdi_in_strobe", {24'd0, last_cdi}, {24'd0, wr ? wd : 8'h00});
        check("setup_tstate", {31'd0, last_setup >= t}, 32'd1);
        check("bus_idle_at_ack", {ior_n, mrq_n, crd_n, ca, cdi}, {3'b111, 16'h0, 8'h0});
        check("bus_stable_no_overlap", unstable + both_low, 0);
        if (wr) begin
            if (io) sh_io[addr[7:0]] = wd;
            else    sh_mem[int'(addr)] = wd;
        end
        exp_rdata = exp;
    endtask

    initial begin : main
        int cap, ackc, a;
        logic [7:0] rd;
        logic er;
        for (int i = 0; i < 256; i++) begin
            blink_io[i] = 8'(i * 37 + 11);
            sh_io[i]    = 8'(i * 37 + 11);
        end
        for (int i = 0; i < 65536; i++) blink_mem[i] = mem_init(16'(i));
        phase = $urandom_range(0, 2);

        // reset held with inputs toggling
        repeat (6) begin
            @(negedge mck);
            req = 1'($urandom); req_io = 1'($urandom); req_wr = 1'($urandom);
            req_addr = 16'($urandom); req_wdata = 8'($urandom);
        end
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_ca", {16'd0, ca}, 32'd0);
        check("rst_cdi", {24'd0, cdi}, 32'd0);
        check("rst_strobes", {27'd0, mrq_n, ior_n, crd_n, cm1_n, hlt_n}, 32'h1F);
        req = 1'b0;
        rin_n = 1'b1;
        repeat (3) @(negedge mck);

        // I/O write 0x42 to port D1
        txn(1'b1, 1'b1, 16'h00D1, 8'h42, 3);
        check("blink_reg_d1", {24'd0, blink_io[8'hD1]}, 32'h42);

        // I/O read, responder returns 0x5A
        blink_io[8'hB2] = 8'h5A;
        sh_io[8'hB2]    = 8'h5A;
        txn(1'b1, 1'b0, 16'hFEB2, 8'h00, 3);

        // memory reads back to back
        txn(1'b0, 1'b0, 16'h2000, 8'h00, 3);
        txn(1'b0, 1'b0, 16'h2001, 8'h00, 3);

        // timeout with pm1 stopped, plus a req poke while busy
        pm1_period = 0;
        repeat (6) @(negedge mck);
        issue(1'b1, 1'b0, 16'h12B2, 8'h00, 100, cap, ackc, rd, er);
        check("tout_latency", ackc - cap, TO + 1);
        check("tout_err", {31'd0, er}, 32'd1);
        check("tout_rdata", {24'd0, rd}, 32'hFF);
        check("tout_strobes", {ior_n, mrq_n, crd_n}, 3'b111);
        check("tout_no_strobe", last_w, -1);
        exp_rdata = 8'hFF;
        a = ack_cnt;
        pm1_period = 3;
        repeat (40) @(negedge mck);
        #1;
        check("tout_no_extra_txn", {ack_cnt, busy}, {a, 1'b0});

        // asynchronous reset in the middle of an I/O write strobe
        @(negedge mck);
        req = 1'b1; req_io = 1'b1; req_wr = 1'b1; req_addr = 16'h00D1; req_wdata = 8'h99;
        @(negedge mck);
        req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!ior_n) break;
            @(negedge mck);
        end
        check("rstmid_strobe_reached", {31'd0, ior_n}, 32'd0);
        repeat (2) @(negedge mck);
        @(posedge mck);
        #2 rin_n = 1'b0;
        #1;
        check("rstmid_strobes", {mrq_n, ior_n, crd_n}, 3'b111);
        check("rstmid_busy_ack", {busy, ack}, 2'b00);
        check("rstmid_bus", {ca, cdi, rdata}, 32'd0);
        a = ack_cnt;
        @(negedge mck);
        rin_n = 1'b1;
        repeat (20) @(negedge mck);
        #1;
        check("rstmid_no_ack", ack_cnt, a);
        exp_rdata = 8'h00;
        txn(1'b1, 1'b1, 16'h00D1, 8'h37, 3);
        txn(1'b1, 1'b0, 16'h00D1, 8'h00, 3);

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            bit rio, rwr;
            logic [15:0] raddr;
            logic [7:0] rwd;
            int rt;
            rio   = 1'($urandom);
            rwr   = 1'($urandom);
            raddr = 16'($urandom_range(1, 65535));
            rwd   = 8'($urandom);
            rt    = $urandom_range(2, 5);
            repeat ($urandom_range(0, 3)) @(negedge mck);
            txn(rio, rwr, raddr, rwd, rt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
